// File: rtl/systolic_mac_pe_pkg.sv
// Shared tensor-core types and default widths for the systolic MAC processing element.
package systolic_mac_pe_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ACC_W_DEF  = 32;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2
    } mac_state_t;

endpackage

// File: rtl/systolic_mac_mul.sv
// Signed DATA_W x DATA_W multiplier, MUL_CYCLES register stages deep, no handshake.
module systolic_mac_mul #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    output logic signed [2*DATA_W-1:0] p
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [PROD_W-1:0] pipe_d [MUL_CYCLES];
    logic signed [PROD_W-1:0] pipe_q [MUL_CYCLES];

    always_comb begin
        a_ext     = PROD_W'(a);
        b_ext     = PROD_W'(b);
        pipe_d[0] = a_ext * b_ext;
        for (int i = 1; i < int'(MUL_CYCLES); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(MUL_CYCLES); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(MUL_CYCLES); i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign p = pipe_q[MUL_CYCLES-1];

endmodule

// File: rtl/systolic_mac_pe.sv
// Weight-stationary systolic MAC PE: out_accumulate = in_accumulate + in_value * active weight.
module systolic_mac_pe
    import systolic_mac_pe_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned ACC_W      = ACC_W_DEF,
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              weight_load,
    input  logic [DATA_W-1:0] weight_in,
    output logic [DATA_W-1:0] weight_out,
    input  logic              weight_swap,
    input  logic              start,
    input  logic [DATA_W-1:0] in_value,
    input  logic [ACC_W-1:0]  in_accumulate,
    input  logic              sat_en,
    input  logic              clear_ovf,
    output logic [DATA_W-1:0] out_value,
    output logic              out_value_valid,
    output logic [ACC_W-1:0]  out_accumulate,
    output logic              out_valid,
    output logic              busy,
    output logic              ovf
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    mac_state_t               state_d, state_q;
    logic [CNT_W-1:0]         cnt_d, cnt_q;
    logic signed [DATA_W-1:0] a_d, a_q;
    logic signed [DATA_W-1:0] w_d, w_q;
    logic signed [ACC_W-1:0]  acc_op_d, acc_op_q;
    logic                     sat_d, sat_q;
    logic [DATA_W-1:0]        shadow_d, shadow_q;
    logic [DATA_W-1:0]        active_d, active_q;
    logic [DATA_W-1:0]        out_value_d, out_value_q;
    logic                     out_value_valid_d, out_value_valid_q;
    logic [ACC_W-1:0]         out_acc_d, out_acc_q;
    logic                     out_valid_d, out_valid_q;
    logic                     busy_d, busy_q;
    logic                     ovf_d, ovf_q;

    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W:0]    sum_c;
    logic                     sum_ovf_c;
    logic [ACC_W-1:0]         result_c;

    systolic_mac_mul #(
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .CLK (CLK),
        .RST (RST),
        .a   (a_q),
        .b   (w_q),
        .p   (prod_c)
    );

    // One guard bit above ACC_W exposes signed overflow as a sign disagreement.
    always_comb begin
        sum_c     = (ACC_W+1)'(acc_op_q) + (ACC_W+1)'(prod_c);
        sum_ovf_c = sum_c[ACC_W] ^ sum_c[ACC_W-1];
        result_c  = sum_c[ACC_W-1:0];
        if (sum_ovf_c && sat_q) begin
            result_c = sum_c[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        a_d               = a_q;
        w_d               = w_q;
        acc_op_d          = acc_op_q;
        sat_d             = sat_q;
        out_value_d       = out_value_q;
        out_value_valid_d = 1'b0;
        out_acc_d         = out_acc_q;
        out_valid_d       = 1'b0;
        ovf_d             = ovf_q;
        shadow_d          = weight_load ? weight_in : shadow_q;
        active_d          = weight_swap ? shadow_q : active_q;

        if (clear_ovf) begin
            ovf_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d           = MUL;
                    cnt_d             = CNT_W'(MUL_CYCLES - 1);
                    a_d               = in_value;
                    w_d               = active_q;
                    acc_op_d          = in_accumulate;
                    sat_d             = sat_en;
                    out_value_d       = in_value;
                    out_value_valid_d = 1'b1;
                end
            end
            MUL: begin
                if (cnt_q == '0) begin
                    state_d = ACC;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACC: begin
                out_acc_d   = result_c;
                out_valid_d = 1'b1;
                if (sum_ovf_c) begin
                    ovf_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            a_q               <= '0;
            w_q               <= '0;
            acc_op_q          <= '0;
            sat_q             <= 1'b0;
            shadow_q          <= '0;
            active_q          <= '0;
            out_value_q       <= '0;
            out_value_valid_q <= 1'b0;
            out_acc_q         <= '0;
            out_valid_q       <= 1'b0;
            busy_q            <= 1'b0;
            ovf_q             <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            a_q               <= a_d;
            w_q               <= w_d;
            acc_op_q          <= acc_op_d;
            sat_q             <= sat_d;
            shadow_q          <= shadow_d;
            active_q          <= active_d;
            out_value_q       <= out_value_d;
            out_value_valid_q <= out_value_valid_d;
            out_acc_q         <= out_acc_d;
            out_valid_q       <= out_valid_d;
            busy_q            <= busy_d;
            ovf_q             <= ovf_d;
        end
    end

    assign weight_out      = shadow_q;
    assign out_value       = out_value_q;
    assign out_value_valid = out_value_valid_q;
    assign out_accumulate  = out_acc_q;
    assign out_valid       = out_valid_q;
    assign busy            = busy_q;
    assign ovf             = ovf_q;

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Scoreboard bench for systolic_mac_pe: stimulus pushes expected results, a monitor pops on valid.
module tb_systolic_mac_pe;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        weight_load = 1'b0;
    logic [15:0] weight_in = '0;
    logic [15:0] weight_out;
    logic        weight_swap = 1'b0;
    logic        start = 1'b0;
    logic [15:0] in_value = '0;
    logic [31:0] in_accumulate = '0;
    logic        sat_en = 1'b0;
    logic        clear_ovf = 1'b0;
    logic [15:0] out_value;
    logic        out_value_valid;
    logic [31:0] out_accumulate;
    logic        out_valid;
    logic        busy;
    logic        ovf;

    typedef struct {
        logic [31:0] acc;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] vq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          res_cnt = 0;
    int          ovv_cnt = 0;

    systolic_mac_pe #(.DATA_W(16), .ACC_W(32), .MUL_CYCLES(2)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .weight_load     (weight_load),
        .weight_in       (weight_in),
        .weight_out      (weight_out),
        .weight_swap     (weight_swap),
        .start           (start),
        .in_value        (in_value),
        .in_accumulate   (in_accumulate),
        .sat_en          (sat_en),
        .clear_ovf       (clear_ovf),
        .out_value       (out_value),
        .out_value_valid (out_value_valid),
        .out_accumulate  (out_accumulate),
        .out_valid       (out_valid),
        .busy            (busy),
        .ovf             (ovf)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: compare every presented result against the head of the scoreboard.
    always @(negedge CLK) begin
        if (out_valid) begin
            res_cnt++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_out_valid: got acc=%h at cycle %0d, none expected", out_accumulate, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_accumulate !== e.acc || (e.due >= 0 && cyc != e.due)) begin
                    miscompares++;
                    $display("FAIL out_accumulate: got %h at cycle %0d, expected %h at cycle %0d",
                             out_accumulate, cyc, e.acc, e.due);
                end
            end
        end
        if (out_value_valid) begin
            ovv_cnt++;
            vectors++;
            if (vq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_out_value_valid: got out_value=%h", out_value);
            end else begin
                logic [15:0] ev;
                ev = vq.pop_front();
                if (out_value !== ev) begin
                    miscompares++;
                    $display("FAIL out_value: got %h, expected %h", out_value, ev);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load_swap(input logic [15:0] w);
        weight_in   = w;
        weight_load = 1'b1;
        tick();
        weight_load = 1'b0;
        weight_swap = 1'b1;
        tick();
        weight_swap = 1'b0;
    endtask

    // Issue one op from IDLE; result is due four sampled cycles later (accept edge + 3).
    task automatic do_op(input logic [15:0] v, input logic [31:0] acc, input logic sat,
                         input logic [31:0] exp_acc);
        exp_t e;
        in_value      = v;
        in_accumulate = acc;
        sat_en        = sat;
        start         = 1'b1;
        e.acc         = exp_acc;
        e.due         = cyc + 4;
        sb.push_back(e);
        vq.push_back(v);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || vq.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        if (sb.size() != 0 || vq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: %0d results and %0d values still outstanding", sb.size(), vq.size());
            sb.delete();
            vq.delete();
        end
        tick();
    endtask

    initial begin
        int r0;
        int v0;
        exp_t e;

        repeat (2) tick();
        RST = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_out_acc", out_accumulate, 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_weight_out", 32'(weight_out), 32'd0);

        // Basic: 3 * 5 + 10, result exactly 3 cycles after accept.
        load_swap(16'd3);
        do_op(16'd5, 32'd10, 1'b0, 32'd25);
        chk("busy_in_mul", 32'(busy), 32'd1);
        wait_idle();
        chk("out_acc_held", out_accumulate, 32'd25);

        // Negative operands.
        load_swap(16'hFFFC);
        do_op(16'd7, 32'd0, 1'b0, 32'hFFFFFFE4);
        wait_idle();

        // Saturating and wrapping overflow, sticky ovf.
        load_swap(16'd1);
        do_op(16'h0020, 32'h7FFFFFF0, 1'b1, 32'h7FFFFFFF);
        wait_idle();
        chk("ovf_after_sat_pos", 32'(ovf), 32'd1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'd0);
        load_swap(16'hFFFF);
        do_op(16'd1, 32'h80000000, 1'b1, 32'h80000000);
        wait_idle();
        chk("ovf_after_sat_neg", 32'(ovf), 32'd1);
        clear_ovf = 1'b1;
        tick();
        load_swap(16'd1);
        do_op(16'h0020, 32'h7FFFFFF0, 1'b0, 32'h80000010);
        repeat (3) tick();
        clear_ovf = 1'b0;
        chk("ovf_set_beats_clear", 32'(ovf), 32'd1);
        wait_idle();

        // Coincident load and swap: old shadow goes active, new value into shadow.
        weight_in   = 16'd5;
        weight_load = 1'b1;
        tick();
        weight_in   = 16'd6;
        weight_swap = 1'b1;
        tick();
        weight_load = 1'b0;
        weight_swap = 1'b0;
        chk("shadow_after_coincide", 32'(weight_out), 32'd6);
        do_op(16'd2, 32'd0, 1'b0, 32'd10);
        wait_idle();

        // Start held for nine cycles: three ops, identical results.
        load_swap(16'd4);
        r0 = res_cnt;
        v0 = ovv_cnt;
        for (int i = 0; i < 3; i++) begin
            e.acc = 32'd107;
            e.due = -1;
            sb.push_back(e);
            vq.push_back(16'd25);
        end
        in_value      = 16'd25;
        in_accumulate = 32'd7;
        sat_en        = 1'b0;
        start         = 1'b1;
        repeat (9) tick();
        start = 1'b0;
        wait_idle();
        repeat (4) tick();
        chk("burst_results", 32'(res_cnt - r0), 32'd3);
        chk("burst_value_pulses", 32'(ovv_cnt - v0), 32'd3);

        // Swap to 9 mid-MUL of a w=2 op.
        load_swap(16'd2);
        weight_in   = 16'd9;
        weight_load = 1'b1;
        do_op(16'd3, 32'd1, 1'b0, 32'd7);
        weight_load = 1'b0;
        weight_swap = 1'b1;
        tick();
        weight_swap = 1'b0;
        wait_idle();
        do_op(16'd3, 32'd1, 1'b0, 32'd28);
        wait_idle();

        // Reset in second MUL cycle aborts with no result and clears everything.
        chk("ovf_before_reset", 32'(ovf), 32'd1);
        in_value      = 16'd11;
        in_accumulate = 32'd5;
        start         = 1'b1;
        vq.push_back(16'd11);
        tick();
        start = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_acc", out_accumulate, 32'd0);
        chk("rst_out_value", 32'(out_value), 32'd0);
        chk("rst_out_value_valid", 32'(out_value_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_weight_out", 32'(weight_out), 32'd0);
        repeat (5) tick();
        do_op(16'd5, 32'd100, 1'b0, 32'd100);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
